// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : alu_pkg
// Description : Shared opcode encodings and default constants for the ALU.
// Revision    : 1.0 - initial release
// ============================================================================
package alu_pkg;

    // Sixteen opcode encodings; RSVD_E/RSVD_F produce a zero result
    typedef enum logic [3:0] {
        AND    = 4'b0000,
        OR     = 4'b0001,
        XOR    = 4'b0010,
        NOR    = 4'b0011,
        NAND   = 4'b0100,
        NOT    = 4'b0101,
        ADD    = 4'b0110,
        SUB    = 4'b0111,
        SLT    = 4'b1000,
        MULT   = 4'b1001,
        DIV    = 4'b1010,
        MOD    = 4'b1011,
        SLA    = 4'b1100,
        SRA    = 4'b1101,
        RSVD_E = 4'b1110,
        RSVD_F = 4'b1111
    } alu_op_e;

    // Default fixed shift distance for SLA/SRA
    localparam int c_shamt_default = 4;

endpackage
`default_nettype wire

// File: rtl/alu_addsub.sv
`default_nettype none
// ============================================================================
// Module      : alu_addsub
// Description : WIDTH-bit adder/subtractor shared by ADD, SUB and SLT.
//               Subtraction is a + ~b + 1, so carry-out = 1 means no borrow.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_addsub #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic             i_sub,
    output logic [WIDTH-1:0] o_sum,
    output logic             o_carry,
    output logic             o_overflow
);

    logic [WIDTH-1:0] w_b_eff;
    logic [WIDTH:0]   w_full;

    // Invert b and inject the +1 through the carry-in when subtracting
    assign w_b_eff = i_sub ? ~i_b : i_b;
    assign w_full  = {1'b0, i_a} + {1'b0, w_b_eff} + {{WIDTH{1'b0}}, i_sub};

    assign o_sum   = w_full[WIDTH-1:0];
    assign o_carry = w_full[WIDTH];

    // Signed overflow: both addends share a sign that the sum does not
    assign o_overflow = (i_a[WIDTH-1] == w_b_eff[WIDTH-1]) &&
                        (w_full[WIDTH-1] != i_a[WIDTH-1]);

endmodule
`default_nettype wire

// File: rtl/alu.sv
`default_nettype none
// ============================================================================
// Module      : alu
// Description : Parameterized signed integer ALU with registered result and
//               zero/negative/carryout/overflow flags, one result per clock.
//               Define ALU_MULDIV_EN to build the MULT/DIV/MOD hardware;
//               without it those opcodes return 0 like the reserved codes.
// Revision    : 1.0 - initial release
// ============================================================================
module alu
    import alu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int SHAMT = c_shamt_default
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic signed [WIDTH-1:0] a,
    input  logic signed [WIDTH-1:0] b,
    input  logic        [3:0]       opcode,
    output logic signed [WIDTH-1:0] result,
    output logic                    zero,
    output logic                    negative,
    output logic                    carryout,
    output logic                    overflow
);

    generate
        if (!(WIDTH == 8 || WIDTH == 16 || WIDTH == 32)) begin : g_bad_width
            $error("alu: WIDTH must be 8, 16 or 32");
        end
        if (SHAMT < 0 || SHAMT >= WIDTH) begin : g_bad_shamt
            $error("alu: SHAMT must lie in 0..WIDTH-1");
        end
    endgenerate

    alu_op_e                 w_op;
    logic                    w_sub;
    logic [WIDTH-1:0]        w_sum;
    logic                    w_as_carry;
    logic                    w_as_ovf;
    logic                    w_lt;
    logic signed [WIDTH-1:0] w_result;
    logic                    w_carry;
    logic                    w_ovf;

    assign w_op  = alu_op_e'(opcode);
    // SLT reuses the subtractor: a < b is the sign of a-b corrected by overflow
    assign w_sub = (w_op == SUB) || (w_op == SLT);

    alu_addsub #(
        .WIDTH (WIDTH)
    ) u_addsub (
        .i_a        (a),
        .i_b        (b),
        .i_sub      (w_sub),
        .o_sum      (w_sum),
        .o_carry    (w_as_carry),
        .o_overflow (w_as_ovf)
    );

    assign w_lt = w_sum[WIDTH-1] ^ w_as_ovf;

`ifdef ALU_MULDIV_EN
    localparam logic [WIDTH-1:0] c_min_neg = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [WIDTH-1:0] c_one     = {{(WIDTH-1){1'b0}}, 1'b1};

    logic signed [2*WIDTH-1:0] w_a_ext;
    logic signed [2*WIDTH-1:0] w_b_ext;
    logic signed [2*WIDTH-1:0] w_prod;
    logic        [WIDTH-1:0]   w_mul_lo;
    logic                      w_mul_ovf;
    logic                      w_div_zero;
    logic                      w_div_ovf;
    logic signed [WIDTH-1:0]   w_div_b;
    logic signed [WIDTH-1:0]   w_quot;
    logic signed [WIDTH-1:0]   w_rem;

    // Full-width signed product; overflow when the high half is not a sign extension
    assign w_a_ext   = {{WIDTH{a[WIDTH-1]}}, a};
    assign w_b_ext   = {{WIDTH{b[WIDTH-1]}}, b};
    assign w_prod    = w_a_ext * w_b_ext;
    assign w_mul_lo  = w_prod[WIDTH-1:0];
    assign w_mul_ovf = (w_prod[2*WIDTH-1:WIDTH] != {WIDTH{w_mul_lo[WIDTH-1]}});

    // Exception cases divide by 1 instead: min/-1 then yields min and 0 directly,
    // and divide-by-zero never reaches the divider
    assign w_div_zero = (b == '0);
    assign w_div_ovf  = (a == c_min_neg) && (b == '1);
    assign w_div_b    = (w_div_zero || w_div_ovf) ? c_one : b;
    assign w_quot     = a / w_div_b;
    assign w_rem      = a % w_div_b;
`endif

    // Opcode mux and ADD/SUB/MULT/DIV/MOD flag selection
    always_comb begin
        w_result = '0;
        w_carry  = 1'b0;
        w_ovf    = 1'b0;
        case (w_op)
            AND:  w_result = a & b;
            OR:   w_result = a | b;
            XOR:  w_result = a ^ b;
            NOR:  w_result = ~(a | b);
            NAND: w_result = ~(a & b);
            NOT:  w_result = ~a;
            ADD, SUB: begin
                w_result = w_sum;
                w_carry  = w_as_carry;
                w_ovf    = w_as_ovf;
            end
            SLT:  w_result = {{(WIDTH-1){1'b0}}, w_lt};
`ifdef ALU_MULDIV_EN
            MULT: begin
                w_result = w_mul_lo;
                w_ovf    = w_mul_ovf;
            end
            DIV: begin
                w_result = w_div_zero ? '0 : w_quot;
                w_ovf    = w_div_zero || w_div_ovf;
            end
            MOD: begin
                w_result = w_div_zero ? a : w_rem;
                w_ovf    = w_div_zero || w_div_ovf;
            end
`endif
            SLA:  w_result = a <<< SHAMT;
            SRA:  w_result = a >>> SHAMT;
            default: w_result = '0;
        endcase
    end

    // Output registers; reset clears everything immediately
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            result   <= '0;
            zero     <= 1'b0;
            negative <= 1'b0;
            carryout <= 1'b0;
            overflow <= 1'b0;
        end else begin
            result   <= w_result;
            zero     <= (w_result == '0);
            negative <= w_result[WIDTH-1];
            carryout <= w_carry;
            overflow <= w_ovf;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_alu.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu
// Description : Self-checking bench for alu at WIDTH 32/16/8: directed cases
//               plus randomized back-to-back traffic against an arithmetic model.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_alu;
    import alu_pkg::*;

    localparam int     SH    = c_shamt_default;
    localparam longint MIN32 = -64'sd2147483648;
    localparam longint MAX32 = 64'sd2147483647;

    typedef struct {
        logic [3:0] op;
        longint     a;
        longint     b;
        longint     r;
        logic [3:0] f;   // {zero, negative, carryout, overflow}
        string      name;
    } dcase_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [3:0] opcode = 4'h0;
    logic signed [31:0] a32 = '0, b32 = '0, r32;
    logic signed [15:0] a16 = '0, b16 = '0, r16;
    logic signed [7:0]  a8  = '0, b8  = '0, r8;
    logic z32, n32, c32, v32, z16, n16, c16, v16, z8, n8, c8, v8;

    int checks = 0;
    int passes = 0;
    bit muldiv_en;

    always #5 clk = ~clk;

    alu #(.WIDTH(32)) dut (
        .clk(clk), .rst(rst), .a(a32), .b(b32), .opcode(opcode),
        .result(r32), .zero(z32), .negative(n32), .carryout(c32), .overflow(v32)
    );
    alu #(.WIDTH(16)) dut16 (
        .clk(clk), .rst(rst), .a(a16), .b(b16), .opcode(opcode),
        .result(r16), .zero(z16), .negative(n16), .carryout(c16), .overflow(v16)
    );
    alu #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .a(a8), .b(b8), .opcode(opcode),
        .result(r8), .zero(z8), .negative(n8), .carryout(c8), .overflow(v8)
    );

    // Two's-complement wrap of x into w bits, returned sign-extended
    function automatic longint sx(input longint x, input int w);
        longint m;
        m = x & ((longint'(1) << w) - 1);
        if (m >= (longint'(1) << (w - 1))) m = m - (longint'(1) << w);
        return m;
    endfunction

    // Reference: exact arithmetic on wide integers, then wrap and derive flags
    function automatic void ref_alu(input int w, input logic [3:0] op, input longint sa,
                                    input longint sb, output longint r, output logic [3:0] f);
        longint mask, minv, full;
        logic c, v;
        mask = (longint'(1) << w) - 1;
        minv = -(longint'(1) << (w - 1));
        c = 1'b0; v = 1'b0; r = 0;
        case (op)
            4'd0: r = sx(sa & sb, w);
            4'd1: r = sx(sa | sb, w);
            4'd2: r = sx(sa ^ sb, w);
            4'd3: r = sx(~(sa | sb), w);
            4'd4: r = sx(~(sa & sb), w);
            4'd5: r = sx(~sa, w);
            4'd6: begin
                full = sa + sb; r = sx(full, w); v = (full != r);
                c = ((((sa & mask) + (sb & mask)) >> w) & 1) != 0;
            end
            4'd7: begin
                full = sa - sb; r = sx(full, w); v = (full != r);
                c = ((sa & mask) >= (sb & mask));
            end
            4'd8: r = (sa < sb) ? 1 : 0;
            4'd9: if (muldiv_en) begin full = sa * sb; r = sx(full, w); v = (full != r); end
            4'd10: if (muldiv_en) begin
                if (sb == 0) begin r = 0; v = 1'b1; end
                else if (sa == minv && sb == -1) begin r = minv; v = 1'b1; end
                else r = sa / sb;
            end
            4'd11: if (muldiv_en) begin
                if (sb == 0) begin r = sa; v = 1'b1; end
                else if (sa == minv && sb == -1) begin r = 0; v = 1'b1; end
                else r = sa % sb;
            end
            4'd12: r = sx(sa << SH, w);
            4'd13: r = sa >>> SH;
            default: r = 0;
        endcase
        f = {r == 0, r < 0, c, v};
    endfunction

    function automatic longint pick(input int w);
        longint minv;
        minv = -(longint'(1) << (w - 1));
        case ($urandom_range(0, 5))
            0: return 0;
            1: return -1;
            2: return minv;
            3: return -minv - 1;
            4: return longint'($urandom_range(0, 20)) - 10;
            default: return sx({$urandom(), $urandom()}, w);
        endcase
    endfunction

    // Apply one 32-bit operation and sample the registered outputs one edge later
    task automatic drive32(input logic [3:0] op, input longint a, input longint b,
                           output logic [35:0] got);
        opcode = op; a32 = a[31:0]; b32 = b[31:0];
        @(posedge clk); #1;
        got = {r32, z32, n32, c32, v32};
    endtask

    task automatic test_reset();
        opcode = 4'h1; a32 = 32'd7; b32 = 32'd9; a16 = 16'd3; a8 = 8'd3;
        repeat (2) @(negedge clk);
        #1;
        checks++;
        if ({r32, z32, n32, c32, v32} !== 36'd0)
            $display("FAIL reset32: got %h, want 0", {r32, z32, n32, c32, v32});
        else passes++;
        checks++;
        if ({r16, z16, n16, c16, v16, r8, z8, n8, c8, v8} !== 32'd0)
            $display("FAIL reset16_8: got %h, want 0", {r16, z16, n16, c16, v16, r8, z8, n8, c8, v8});
        else passes++;
        @(negedge clk) rst = 1'b0;
        a16 = '0; a8 = '0;
        @(posedge clk); #1;
    endtask

    task automatic test_logic();
        dcase_t t[$];
        logic [35:0] got;
        t.push_back('{4'h0,   1,   0,   0, 4'b1000, "and"});
        t.push_back('{4'h1,   0,   1,   1, 4'b0000, "or"});
        t.push_back('{4'h2,   1,   1,   0, 4'b1000, "xor"});
        t.push_back('{4'h3,   1,   0,  -2, 4'b0100, "nor"});
        t.push_back('{4'h4, -54, -32,  63, 4'b0000, "nand"});
        t.push_back('{4'h5,  24,  99, -25, 4'b0100, "not"});
        foreach (t[i]) begin
            drive32(t[i].op, t[i].a, t[i].b, got);
            checks++;
            if (got !== {t[i].r[31:0], t[i].f})
                $display("FAIL %s: got r=%0d f=%b, want r=%0d f=%b",
                         t[i].name, $signed(got[35:4]), got[3:0], t[i].r, t[i].f);
            else passes++;
        end
    endtask

    task automatic test_addsub_slt();
        dcase_t t[$];
        logic [35:0] got;
        t.push_back('{4'h6, MAX32,  1, MIN32, 4'b0101, "add_ovf"});
        t.push_back('{4'h6,    -1,  1,     0, 4'b1010, "add_carry"});
        t.push_back('{4'h7,     5,  4,     1, 4'b0010, "sub"});
        t.push_back('{4'h7, MIN32,  1, MAX32, 4'b0011, "sub_ovf"});
        t.push_back('{4'h8,     3, 10,     1, 4'b0000, "slt_true"});
        t.push_back('{4'h8,    10,  3,     0, 4'b1000, "slt_false"});
        t.push_back('{4'h8, MIN32, MAX32,  1, 4'b0000, "slt_extreme"});
        foreach (t[i]) begin
            drive32(t[i].op, t[i].a, t[i].b, got);
            checks++;
            if (got !== {t[i].r[31:0], t[i].f})
                $display("FAIL %s: got r=%0d f=%b, want r=%0d f=%b",
                         t[i].name, $signed(got[35:4]), got[3:0], t[i].r, t[i].f);
            else passes++;
        end
    endtask

    task automatic test_width_add_overflow();
        opcode = 4'h6;
        a32 = 32'sh7fffffff; b32 = 32'sd1;
        a16 = 16'sh7fff;     b16 = 16'sd1;
        a8  = 8'sh7f;        b8  = 8'sd1;
        @(posedge clk); #1;
        checks++;
        if ({r16, z16, n16, c16, v16} !== {16'h8000, 4'b0101})
            $display("FAIL add_ovf16: got r=%0d f=%b, want r=-32768 f=0101", r16, {z16, n16, c16, v16});
        else passes++;
        checks++;
        if ({r8, z8, n8, c8, v8} !== {8'h80, 4'b0101})
            $display("FAIL add_ovf8: got r=%0d f=%b, want r=-128 f=0101", r8, {z8, n8, c8, v8});
        else passes++;
        a16 = '0; b16 = '0; a8 = '0; b8 = '0;
    endtask

    task automatic test_muldiv();
        dcase_t t[$];
        logic [35:0] got;
`ifdef ALU_MULDIV_EN
        t.push_back('{4'h9,       4,       2,     8, 4'b0000, "mult"});
        t.push_back('{4'h9, 65536, 65536,         0, 4'b1001, "mult_ovf"});
        t.push_back('{4'hA,      10,       5,     2, 4'b0000, "div"});
        t.push_back('{4'hB,       4,       3,     1, 4'b0000, "mod"});
        t.push_back('{4'hB,      -7,       2,    -1, 4'b0100, "mod_neg"});
        t.push_back('{4'hA,       7,       0,     0, 4'b1001, "div_zero"});
        t.push_back('{4'hB,       7,       0,     7, 4'b0001, "mod_zero"});
        t.push_back('{4'hA,   MIN32,      -1, MIN32, 4'b0101, "div_minneg"});
        t.push_back('{4'hB,   MIN32,      -1,     0, 4'b1001, "mod_minneg"});
`else
        t.push_back('{4'h9,  4,  2, 0, 4'b1000, "mult_off"});
        t.push_back('{4'hA, 10,  5, 0, 4'b1000, "div_off"});
        t.push_back('{4'hB,  4,  3, 0, 4'b1000, "mod_off"});
        t.push_back('{4'hA,  7,  0, 0, 4'b1000, "div_zero_off"});
`endif
        foreach (t[i]) begin
            drive32(t[i].op, t[i].a, t[i].b, got);
            checks++;
            if (got !== {t[i].r[31:0], t[i].f})
                $display("FAIL %s: got r=%0d f=%b, want r=%0d f=%b",
                         t[i].name, $signed(got[35:4]), got[3:0], t[i].r, t[i].f);
            else passes++;
        end
    endtask

    task automatic test_shift_default();
        dcase_t t[$];
        logic [35:0] got;
        t.push_back('{4'hC, -2,  0, -32, 4'b0100, "sla"});
        t.push_back('{4'hD,  8,  0,   0, 4'b1000, "sra"});
        t.push_back('{4'hD, -256, 0, -16, 4'b0100, "sra_neg"});
        t.push_back('{4'hE, 10, 10,   0, 4'b1000, "rsvd_e"});
        t.push_back('{4'hF, -5,  3,   0, 4'b1000, "rsvd_f"});
        foreach (t[i]) begin
            drive32(t[i].op, t[i].a, t[i].b, got);
            checks++;
            if (got !== {t[i].r[31:0], t[i].f})
                $display("FAIL %s: got r=%0d f=%b, want r=%0d f=%b",
                         t[i].name, $signed(got[35:4]), got[3:0], t[i].r, t[i].f);
            else passes++;
        end
    endtask

    task automatic test_async_reset();
        logic [35:0] got;
        drive32(4'h1, 0, 5, got);
        checks++;
        if (got !== {32'd5, 4'b0000})
            $display("FAIL areset_load: got r=%0d f=%b, want r=5 f=0000", $signed(got[35:4]), got[3:0]);
        else passes++;
        #1 rst = 1'b1;
        #1;
        checks++;
        if ({r32, z32, n32, c32, v32} !== 36'd0)
            $display("FAIL areset_clear: got %h, want 0", {r32, z32, n32, c32, v32});
        else passes++;
        #1 rst = 1'b0;
        @(posedge clk); #1;
        checks++;
        if ({r32, z32, n32, c32, v32} !== {32'd5, 4'b0000})
            $display("FAIL areset_reload: got r=%0d, want r=5", r32);
        else passes++;
    endtask

    task automatic test_random_back_to_back();
        longint rr;
        logic [3:0] ff;
        for (int i = 0; i < 300; i++) begin
            opcode = 4'($urandom_range(0, 15));
            a32 = 32'(pick(32)); b32 = 32'(pick(32));
            a16 = 16'(pick(16)); b16 = 16'(pick(16));
            a8  = 8'(pick(8));   b8  = 8'(pick(8));
            @(posedge clk); #1;
            ref_alu(32, opcode, longint'(a32), longint'(b32), rr, ff);
            checks++;
            if ({r32, z32, n32, c32, v32} !== {rr[31:0], ff})
                $display("FAIL rand32 op=%h a=%0d b=%0d: got r=%0d f=%b, want r=%0d f=%b",
                         opcode, a32, b32, r32, {z32, n32, c32, v32}, rr, ff);
            else passes++;
            ref_alu(16, opcode, longint'(a16), longint'(b16), rr, ff);
            checks++;
            if ({r16, z16, n16, c16, v16} !== {rr[15:0], ff})
                $display("FAIL rand16 op=%h a=%0d b=%0d: got r=%0d f=%b, want r=%0d f=%b",
                         opcode, a16, b16, r16, {z16, n16, c16, v16}, rr, ff);
            else passes++;
            ref_alu(8, opcode, longint'(a8), longint'(b8), rr, ff);
            checks++;
            if ({r8, z8, n8, c8, v8} !== {rr[7:0], ff})
                $display("FAIL rand8 op=%h a=%0d b=%0d: got r=%0d f=%b, want r=%0d f=%b",
                         opcode, a8, b8, r8, {z8, n8, c8, v8}, rr, ff);
            else passes++;
        end
    endtask

    initial begin
`ifdef ALU_MULDIV_EN
        muldiv_en = 1'b1;
`else
        muldiv_en = 1'b0;
`endif
        test_reset();
        test_logic();
        test_addsub_slt();
        test_width_add_overflow();
        test_muldiv();
        test_shift_default();
        test_async_reset();
        test_random_back_to_back();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
`default_nettype wire
